// File: rtl/trigger_capture.sv
`default_nettype none
// =============================================================================
// Module   : trigger_capture
// Purpose  : Sticky per-bit trigger latch with overrun flags and a saturating
//            event count, frozen into a valid/ack snapshot on request.
// Revision : 1.0 - initial release
// =============================================================================
module trigger_capture #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ep_trigger,
    input  logic [WIDTH-1:0] edge_mode,
    input  logic             update_req,
    input  logic             snap_ack,
    output logic [WIDTH-1:0] snap_data,
    output logic [WIDTH-1:0] snap_overrun,
    output logic [CNT_W-1:0] snap_count,
    output logic             snap_valid,
    output logic             busy
);

    localparam int PW     = $clog2(WIDTH + 1);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int N2     = 1 << LEVELS;
    localparam int SUM_W  = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SNAP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_latch;
    logic [WIDTH-1:0] r_ovr;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_ev;
    logic [PW-1:0]    w_pop;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_sat;

    // An edge-mode bit only fires when it was low on the previous cycle.
    assign w_ev = ep_trigger & ~(edge_mode & r_prev);

    // Popcount as a balanced binary tree in heap order; leaves padded to 2^n.
    logic [PW-1:0] w_tree [0:2*N2-2];

    generate
        for (genvar i = 0; i < N2; i++) begin : g_leaf
            if (i < WIDTH) begin : g_real
                assign w_tree[N2-1+i] = PW'(w_ev[i]);
            end else begin : g_pad
                assign w_tree[N2-1+i] = '0;
            end
        end
        for (genvar k = 0; k < N2 - 1; k++) begin : g_node
            assign w_tree[k] = w_tree[2*k+1] + w_tree[2*k+2];
        end
    endgenerate

    assign w_pop = w_tree[0];

    assign w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pop);
    assign w_cnt_sat = (w_sum > SUM_W'(C_CNT_MAX)) ? C_CNT_MAX : w_sum[CNT_W-1:0];

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (update_req) w_state_next = S_SNAP;
            S_SNAP: w_state_next = S_HOLD;
            S_HOLD: if (snap_ack) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_SNAP) || (r_state == S_HOLD);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_prev       <= '0;
            r_latch      <= '0;
            r_ovr        <= '0;
            r_cnt        <= '0;
            snap_data    <= '0;
            snap_overrun <= '0;
            snap_count   <= '0;
            snap_valid   <= 1'b0;
        end else begin
            r_prev <= ep_trigger;
            if (r_state == S_SNAP) begin
                // Events arriving on this edge belong to the snapshot being taken.
                snap_data    <= r_latch | w_ev;
                snap_overrun <= r_ovr | (w_ev & r_latch);
                snap_count   <= w_cnt_sat;
                snap_valid   <= 1'b1;
                r_latch      <= '0;
                r_ovr        <= '0;
                r_cnt        <= '0;
            end else begin
                r_latch <= r_latch | w_ev;
                r_ovr   <= r_ovr | (w_ev & r_latch);
                r_cnt   <= w_cnt_sat;
                if ((r_state == S_HOLD) && snap_ack) begin
                    snap_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// =============================================================================
// Module   : tb_trigger_capture
// Purpose  : Self-checking bench for trigger_capture with an interval-count model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_trigger_capture;

    localparam int W    = 32;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          sys_clk;
    logic          reset;
    logic [W-1:0]  ep_trigger;
    logic [W-1:0]  edge_mode;
    logic          update_req;
    logic          snap_ack;
    logic [W-1:0]  snap_data;
    logic [W-1:0]  snap_overrun;
    logic [CW-1:0] snap_count;
    logic          snap_valid;
    logic          busy;

    trigger_capture #(.WIDTH(W), .CNT_W(CW)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .ep_trigger   (ep_trigger),
        .edge_mode    (edge_mode),
        .update_req   (update_req),
        .snap_ack     (snap_ack),
        .snap_data    (snap_data),
        .snap_overrun (snap_overrun),
        .snap_count   (snap_count),
        .snap_valid   (snap_valid),
        .busy         (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: per-bit event counts for the open interval plus the frozen snapshot.
    localparam int MS_IDLE = 0, MS_SNAP = 1, MS_HOLD = 2;
    int            m_cnt [W];
    int            m_total;
    int            m_state;
    logic [W-1:0]  m_prev;
    logic [W-1:0]  exp_data;
    logic [W-1:0]  exp_ovr;
    int            exp_count;
    logic          exp_valid;

    task automatic model_clear();
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
        m_total   = 0;
        m_state   = MS_IDLE;
        m_prev    = '0;
        exp_data  = '0;
        exp_ovr   = '0;
        exp_count = 0;
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        ep_trigger = '0; update_req = 1'b0; snap_ack = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic step(input logic [W-1:0] trig, input logic req, input logic ack);
        logic e;
        ep_trigger = trig; update_req = req; snap_ack = ack;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < W; i++) begin
            e = edge_mode[i] ? (trig[i] & ~m_prev[i]) : trig[i];
            if (e) begin
                m_cnt[i]++;
                m_total++;
            end
        end
        if (m_state == MS_SNAP) begin
            for (int i = 0; i < W; i++) begin
                exp_data[i] = (m_cnt[i] > 0);
                exp_ovr[i]  = (m_cnt[i] > 1);
                m_cnt[i]    = 0;
            end
            exp_count = (m_total > CMAX) ? CMAX : m_total;
            m_total   = 0;
            exp_valid = 1'b1;
            m_state   = MS_HOLD;
        end else if (m_state == MS_IDLE && req) begin
            m_state = MS_SNAP;
        end else if (m_state == MS_HOLD && ack) begin
            exp_valid = 1'b0;
            m_state   = MS_IDLE;
        end
        m_prev = trig;
    endtask

    task automatic test_reset();
        edge_mode = '0;
        do_reset();
        n_total++;
        if ({snap_valid, busy} !== 2'b00) $display("FAIL reset_ctrl valid/busy=%b required 00", {snap_valid, busy});
        else n_pass++;
        n_total++;
        if ({snap_data, snap_overrun, snap_count} !== '0)
            $display("FAIL reset_data data=%h ovr=%h cnt=%h required all 0", snap_data, snap_overrun, snap_count);
        else n_pass++;
    endtask

    task automatic test_basic();
        edge_mode = 32'h0000_0080;
        do_reset();
        step(32'h0000_0081, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        n_total++;
        if ({snap_valid, busy} !== 2'b01) $display("FAIL basic_latency valid/busy=%b required 01", {snap_valid, busy});
        else n_pass++;
        step('0, 1'b0, 1'b0);
        n_total++;
        if (snap_valid !== 1'b1 || snap_data !== 32'h0000_0081 || snap_overrun !== '0 || snap_count !== 8'd2)
            $display("FAIL basic_snap valid=%b data=%h ovr=%h cnt=%0d required 1 00000081 00000000 2",
                     snap_valid, snap_data, snap_overrun, snap_count);
        else n_pass++;
        step('0, 1'b0, 1'b1);
        n_total++;
        if (snap_valid !== 1'b0 || busy !== 1'b0 || snap_data !== 32'h0000_0081 || snap_count !== 8'd2)
            $display("FAIL basic_ack valid=%b busy=%b data=%h cnt=%0d required 0 0 00000081 2",
                     snap_valid, busy, snap_data, snap_count);
        else n_pass++;
    endtask

    task automatic test_level_and_edge();
        edge_mode = '0;
        repeat (5) step(32'h8, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        n_total++;
        if (snap_data !== 32'h8 || snap_overrun !== 32'h8 || snap_count !== 8'd5)
            $display("FAIL level_hold data=%h ovr=%h cnt=%0d required 00000008 00000008 5",
                     snap_data, snap_overrun, snap_count);
        else n_pass++;
        step('0, 1'b0, 1'b1);
        edge_mode = 32'h8;
        repeat (5) step(32'h8, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        n_total++;
        if (snap_data !== 32'h8 || snap_overrun !== '0 || snap_count !== 8'd1)
            $display("FAIL edge_hold data=%h ovr=%h cnt=%0d required 00000008 00000000 1",
                     snap_data, snap_overrun, snap_count);
        else n_pass++;
        step('0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        edge_mode = '0;
        repeat (20) step('1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        n_total++;
        if (snap_data !== 32'hFFFF_FFFF || snap_overrun !== 32'hFFFF_FFFF || snap_count !== 8'hFF)
            $display("FAIL saturate data=%h ovr=%h cnt=%h required ffffffff ffffffff ff",
                     snap_data, snap_overrun, snap_count);
        else n_pass++;
        step('0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        edge_mode = '0;
        step('0, 1'b1, 1'b0);
        step(32'h4, 1'b0, 1'b0);
        step(32'h20, 1'b1, 1'b0);
        n_total++;
        if (busy !== 1'b1 || snap_valid !== 1'b1 || snap_data !== 32'h4 || snap_count !== 8'd1)
            $display("FAIL snap_edge busy=%b valid=%b data=%h cnt=%0d required 1 1 00000004 1",
                     busy, snap_valid, snap_data, snap_count);
        else n_pass++;
        step('0, 1'b0, 1'b0);
        n_total++;
        if ({snap_valid, busy} !== 2'b11 || snap_data !== 32'h4)
            $display("FAIL req_ignored valid/busy=%b data=%h required 11 00000004", {snap_valid, busy}, snap_data);
        else n_pass++;
        step('0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        n_total++;
        if (snap_data !== 32'h20 || snap_overrun !== '0 || snap_count !== 8'd1)
            $display("FAIL second_snap data=%h ovr=%h cnt=%0d required 00000020 00000000 1",
                     snap_data, snap_overrun, snap_count);
        else n_pass++;
        step('0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_in_hold();
        edge_mode = '0;
        step(32'h81, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        n_total++;
        if (snap_data !== 32'h81 || snap_valid !== 1'b1)
            $display("FAIL pre_reset data=%h valid=%b required 00000081 1", snap_data, snap_valid);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (snap_valid !== 1'b0 || snap_data !== '0 || snap_count !== '0 || busy !== 1'b0)
            $display("FAIL async_reset valid=%b data=%h cnt=%0d busy=%b required 0 0 0 0",
                     snap_valid, snap_data, snap_count, busy);
        else n_pass++;
        @(posedge sys_clk);
        #1 reset = 1'b0;
        model_clear();
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        n_total++;
        if (snap_valid !== 1'b1 || snap_data !== '0 || snap_overrun !== '0 || snap_count !== '0)
            $display("FAIL empty_snap valid=%b data=%h ovr=%h cnt=%0d required 1 0 0 0",
                     snap_valid, snap_data, snap_overrun, snap_count);
        else n_pass++;
        step('0, 1'b0, 1'b1);
    endtask

    task automatic test_ack_rules();
        step('0, 1'b0, 1'b1);
        n_total++;
        if ({snap_valid, busy} !== 2'b00) $display("FAIL ack_idle valid/busy=%b required 00", {snap_valid, busy});
        else n_pass++;
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1);
        n_total++;
        if ({snap_valid, busy} !== 2'b00) $display("FAIL req_ack_exit valid/busy=%b required 00", {snap_valid, busy});
        else n_pass++;
        step('0, 1'b0, 1'b0);
        n_total++;
        if ({snap_valid, busy} !== 2'b00) $display("FAIL no_queued_snap valid/busy=%b required 00", {snap_valid, busy});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] trig;
        edge_mode = $urandom;
        for (int c = 0; c < 400; c++) begin
            trig = $urandom & $urandom & $urandom;
            if (c % 97 < 12) trig = '1;
            step(trig, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            n_total++;
            if (snap_valid !== exp_valid || busy !== (m_state != MS_IDLE))
                $display("FAIL rand_ctrl cyc=%0d valid=%b busy=%b required %b %b",
                         c, snap_valid, busy, exp_valid, (m_state != MS_IDLE));
            else n_pass++;
            n_total++;
            if (snap_data !== exp_data || snap_overrun !== exp_ovr || snap_count !== CW'(exp_count))
                $display("FAIL rand_snap cyc=%0d data=%h ovr=%h cnt=%0d required %h %h %0d",
                         c, snap_data, snap_overrun, snap_count, exp_data, exp_ovr, exp_count);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; ep_trigger = '0; edge_mode = '0; update_req = 1'b0; snap_ack = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_level_and_edge();
        test_saturation();
        test_back_to_back();
        test_reset_in_hold();
        test_ack_rules();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
